// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: one outstanding instruction-bus request and a
// one-entry output slot toward decode, with redirect/flush handling.
module fetch_ctrl #(
    parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    input  logic        f_ready,
    output logic        ireq_valid,
    output logic [63:0] ireq_addr,
    input  logic        iresp_data_ok,
    input  logic [31:0] iresp_data,
    output logic        f_valid,
    output logic [63:0] f_pc,
    output logic [31:0] f_inst,
    output logic        fetch_busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DROP  = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [63:0] pc, pc_nxt;
    logic [63:0] req_addr;
    logic        fill;
    logic        load_req;

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        fill      = 1'b0;
        load_req  = 1'b0;
        case (state)
            IDLE: begin
                if ((!f_valid || f_ready) && !redirect_valid) begin
                    state_nxt = FETCH;
                    load_req  = 1'b1;
                end
            end
            FETCH: begin
                if (iresp_data_ok) begin
                    state_nxt = IDLE;
                    if (!redirect_valid) begin
                        fill   = 1'b1;
                        pc_nxt = pc + 64'd4;
                    end
                end else if (redirect_valid) begin
                    state_nxt = DROP;
                end
            end
            DROP: begin
                if (iresp_data_ok) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        // A redirect overrides any sequential pc advance; target is word-aligned.
        if (redirect_valid) pc_nxt = {redirect_pc[63:2], 2'b00};
    end

    // req_addr is frozen for the life of a request so DROP keeps the old address.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            pc       <= RESET_PC;
            req_addr <= RESET_PC;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            if (load_req) req_addr <= pc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            f_valid <= 1'b0;
            f_pc    <= 64'd0;
            f_inst  <= 32'd0;
        end else if (redirect_valid) begin
            f_valid <= 1'b0;
        end else if (fill) begin
            f_valid <= 1'b1;
            f_pc    <= pc;
            f_inst  <= iresp_data;
        end else if (f_valid && f_ready) begin
            f_valid <= 1'b0;
        end
    end

    assign ireq_valid = (state != IDLE);
    assign fetch_busy = (state != IDLE);
    assign ireq_addr  = req_addr;

endmodule
